joy_source_select: RTL and testbench
====================================

# joy_source_select

Selects and qualifies the joystick source for the menu core's user-port joystick. It takes both decoded readers (DB9 Mega Drive splitter and DB15 serial) and arbitrates between them with a latched mode FSM and sticky per-player enables. It emits registered joystick words for the HPS I/O block, the user-port mode bits, and a held OSD-combo flag. It sits directly downstream of the two readers and upstream of the hps_io joystick input and USER_MODE/USER_OSD pins.

## Interface
- DET_CYCLES, 16: consecutive synchronized-low cycles needed on a detect pin before a mode decision latches (1..255).
- COMBO_CYCLES, 4: consecutive cycles joy1[10] and joy1[6] must both be held before osd_combo asserts (1..255).

Ports:
- clk  in  1  system clock; all logic is single-clock.
- reset_n  in  1  synchronous, active-low reset.
- md_detect  in  1  raw USER_IN[7]; low means an MD splitter is present.
- db15_pins  in  3  raw {USER_IN[6], USER_IN[3], USER_IN[2]}; any low means no DB15 adapter.
- md_joy1, md_joy2  in  16 each  decoded DB9MD words, already in clk domain.
- db15_joy1, db15_joy2  in  16 each  decoded DB15 words, already in clk domain.
- joy1, joy2  out  16 each  selected, gated joystick words (registered).
- user_mode  out  2  {md_mode, ~md_mode}: 2'b10 in MD, 2'b01 otherwise.
- p1_en, p2_en  out  1 each  sticky player-present flags.
- osd_combo  out  1  high while the OSD combo is held (registered).

## Operation
- md_detect and db15_pins each pass through a 2-FF synchronizer. Decisions use the synchronized values only.
- Mode FSM has three states:
  - PROBE, the reset state: source is DB15.
  - MD: source is md_joy*.
  - NONE: no source.
- Detection counters:
  - md_cnt (8 bit) increments while sync md_detect==0 and clears when it is 1.
  - d15_cnt (8 bit) increments while any sync db15_pin==0 and clears otherwise.
  - Both saturate at DET_CYCLES.
- Transitions:
  - PROBE→MD when md_cnt reaches DET_CYCLES.
  - PROBE→NONE when d15_cnt reaches DET_CYCLES and md_cnt has not.
  - If both reach DET_CYCLES in the same cycle, MD wins.
  - MD and NONE are absorbing until reset.
  - Once in MD, db15_pins are ignored; their lines carry MD data.
- Source word src1/src2: md_joy* in MD, db15_joy* in PROBE, 0 in NONE.
- Player enables:
  - p1_en is set when src1[2]==1.
  - p2_en is set when src2[2]==1 and src1[2]==0 in the same cycle. This suppresses duplicate input when no splitter is fitted.
  - Both are sticky until reset.
- Output gating: joy1/joy2 = (p1_en|p2_en) ? src1/src2 : 0. The enables used are the registered values, so the press that sets an enable is not itself output.
- OSD combo:
  - combo_cnt increments while joy1[10]&joy1[6] and saturates at COMBO_CYCLES.
  - combo_cnt clears in the cycle either bit is low.
  - osd_combo = (combo_cnt==COMBO_CYCLES), registered.

## Timing
- Reset (reset_n==0 at a clk edge) sets:
  - FSM to PROBE; all counters and synchronizers to 0.
  - joy1=joy2=0, p1_en=p2_en=0, osd_combo=0, user_mode=2'b01.
- Reset asserted mid-operation returns to PROBE on the next edge regardless of the current state.
- md_detect low→MD latency:
  - 2 sync cycles + DET_CYCLES counting cycles; the state register updates on the following edge.
  - user_mode changes on the same edge as the state.
- Input word→joy output: 1 cycle (registered), once enables are set.
- First press (src1[2] 0→1): p1_en goes high 1 cycle later; joy1 shows src1 from that cycle's following edge.
- osd_combo rises COMBO_CYCLES+1 cycles after joy1 first shows both bits. It falls 1 cycle after either bit drops.
- A md_detect glitch shorter than DET_CYCLES clears md_cnt and causes no transition.

## Test plan
- Reset with DET_CYCLES=16: all outputs are zero, user_mode=01. Held pins high for 1000 cycles: state stays PROBE.
- Hold md_detect=0 for 15 cycles, release, then hold again for 16 cycles:
  - No transition on the first pulse.
  - user_mode=10 exactly 2+16+1 cycles after the second fall.
  - MD persists after md_detect returns high.
- Drive db15_pins=3'b110 for 16 cycles with md_detect high: state is NONE, joy1/joy2 stay 0 even with db15_joy1=16'hFFFF. Assert reset_n=0 for 1 cycle: state returns to PROBE.
- In PROBE, set db15_joy1=16'h0004, db15_joy2=16'h0004:
  - p1_en=1 and p2_en=0.
  - Then db15_joy1=0, db15_joy2=16'h0005 sets p2_en=1.
  - joy2=16'h0005 one cycle later.
- With p1_en set, hold joy1 bits 10 and 6 for 10 cycles (COMBO_CYCLES=4):
  - osd_combo rises on the 5th cycle after joy1 shows 16'h0440.
  - Dropping bit 6 lowers it 1 cycle later.
- Drive md_detect low and db15_pins=000 together for 16 cycles: state becomes MD, not NONE.

Source files
------------

// File: rtl/joy_source_select.sv
// joy_source_select: picks the menu-core joystick source (DB9 MD splitter or
// DB15 serial), latches the adapter mode, gates words on sticky player enables
// and flags a held OSD combo on player 1.
module joy_source_select #(
    parameter int unsigned DET_CYCLES   = 16,
    parameter int unsigned COMBO_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        md_detect,
    input  logic [2:0]  db15_pins,
    input  logic [15:0] md_joy1,
    input  logic [15:0] md_joy2,
    input  logic [15:0] db15_joy1,
    input  logic [15:0] db15_joy2,
    output logic [15:0] joy1,
    output logic [15:0] joy2,
    output logic [1:0]  user_mode,
    output logic        p1_en,
    output logic        p2_en,
    output logic        osd_combo
);

    localparam int unsigned CNT_W     = 8;
    localparam int unsigned JOY_W     = 16;
    localparam logic [CNT_W-1:0] DET_MAX   = CNT_W'(DET_CYCLES);
    localparam logic [CNT_W-1:0] COMBO_MAX = CNT_W'(COMBO_CYCLES);

    typedef enum logic [1:0] {
        ST_PROBE = 2'd0,
        ST_MD    = 2'd1,
        ST_NONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [1:0]         user_mode_q;

    logic               md_s1_q, md_s2_q;
    logic [2:0]         d15_s1_q, d15_s2_q;

    logic [CNT_W-1:0]   md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0]   d15_cnt_q, d15_cnt_d;
    logic               md_hit, d15_hit;

    logic [JOY_W-1:0]   src1, src2;
    logic [JOY_W-1:0]   joy1_q, joy1_d;
    logic [JOY_W-1:0]   joy2_q, joy2_d;
    logic               p1_en_q, p1_en_d;
    logic               p2_en_q, p2_en_d;

    logic               combo_both;
    logic [CNT_W-1:0]   combo_cnt_q, combo_cnt_d;
    logic               osd_combo_q, osd_combo_d;

    // Two-flop synchronizers for the raw detect pins.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            md_s1_q  <= 1'b0;
            md_s2_q  <= 1'b0;
            d15_s1_q <= 3'b000;
            d15_s2_q <= 3'b000;
        end else begin
            md_s1_q  <= md_detect;
            md_s2_q  <= md_s1_q;
            d15_s1_q <= db15_pins;
            d15_s2_q <= d15_s1_q;
        end
    end

    assign md_hit  = (md_cnt_q == DET_MAX);
    assign d15_hit = (d15_cnt_q == DET_MAX);

    // Saturating run-length counters of the active-low detect conditions.
    always_comb begin
        md_cnt_d  = '0;
        d15_cnt_d = '0;
        if (!md_s2_q) begin
            md_cnt_d = md_hit ? md_cnt_q : md_cnt_q + CNT_W'(1);
        end
        if (!(&d15_s2_q)) begin
            d15_cnt_d = d15_hit ? d15_cnt_q : d15_cnt_q + CNT_W'(1);
        end
    end

    // Detection counter registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            md_cnt_q  <= '0;
            d15_cnt_q <= '0;
        end else begin
            md_cnt_q  <= md_cnt_d;
            d15_cnt_q <= d15_cnt_d;
        end
    end

    // Mode FSM; MD has priority when both detectors complete together, and
    // both decided modes hold until reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_PROBE;
            user_mode_q <= 2'b01;
        end else begin
            case (state_q)
                ST_PROBE: begin
                    if (md_hit) begin
                        state_q     <= ST_MD;
                        user_mode_q <= 2'b10;
                    end else if (d15_hit) begin
                        state_q     <= ST_NONE;
                        user_mode_q <= 2'b01;
                    end
                end
                default: begin
                    state_q     <= state_q;
                    user_mode_q <= user_mode_q;
                end
            endcase
        end
    end

    // Source word selection from the latched mode.
    always_comb begin
        src1 = '0;
        src2 = '0;
        case (state_q)
            ST_MD: begin
                src1 = md_joy1;
                src2 = md_joy2;
            end
            ST_PROBE: begin
                src1 = db15_joy1;
                src2 = db15_joy2;
            end
            default: begin
                src1 = '0;
                src2 = '0;
            end
        endcase
    end

    // Sticky enables and gated words; gating uses the enables already held,
    // and p2 only latches when p1 is idle so an unsplit pad is not doubled.
    always_comb begin
        p1_en_d = p1_en_q | src1[2];
        p2_en_d = p2_en_q | (src2[2] & ~src1[2]);
        joy1_d  = (p1_en_q | p2_en_q) ? src1 : '0;
        joy2_d  = (p1_en_q | p2_en_q) ? src2 : '0;
    end

    // OSD combo: count while bits 10 and 6 of the output word are held, and
    // drop the flag in the same cycle either bit goes low.
    assign combo_both = joy1_q[10] & joy1_q[6];

    always_comb begin
        combo_cnt_d = '0;
        if (combo_both) begin
            combo_cnt_d = (combo_cnt_q == COMBO_MAX) ? combo_cnt_q
                                                     : combo_cnt_q + CNT_W'(1);
        end
        osd_combo_d = combo_both && (combo_cnt_q == COMBO_MAX);
    end

    // Output, enable and combo registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            p1_en_q     <= 1'b0;
            p2_en_q     <= 1'b0;
            joy1_q      <= '0;
            joy2_q      <= '0;
            combo_cnt_q <= '0;
            osd_combo_q <= 1'b0;
        end else begin
            p1_en_q     <= p1_en_d;
            p2_en_q     <= p2_en_d;
            joy1_q      <= joy1_d;
            joy2_q      <= joy2_d;
            combo_cnt_q <= combo_cnt_d;
            osd_combo_q <= osd_combo_d;
        end
    end

    assign joy1      = joy1_q;
    assign joy2      = joy2_q;
    assign user_mode = user_mode_q;
    assign p1_en     = p1_en_q;
    assign p2_en     = p2_en_q;
    assign osd_combo = osd_combo_q;

endmodule

// File: tb/tb_joy_source_select.sv
// Bench for joy_source_select: directed vectors, a cycle-level reference model
// checked every cycle, and literal expectations at key points.
module tb_joy_source_select;

    localparam int DET   = 16;
    localparam int COMBO = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        md_detect;
    logic [2:0]  db15_pins;
    logic [15:0] md_joy1, md_joy2, db15_joy1, db15_joy2;
    logic [15:0] joy1, joy2;
    logic [1:0]  user_mode;
    logic        p1_en, p2_en, osd_combo;

    int checks = 0;
    int errors = 0;

    joy_source_select #(.DET_CYCLES(DET), .COMBO_CYCLES(COMBO)) dut (
        .clk(clk), .reset_n(reset_n), .md_detect(md_detect), .db15_pins(db15_pins),
        .md_joy1(md_joy1), .md_joy2(md_joy2), .db15_joy1(db15_joy1), .db15_joy2(db15_joy2),
        .joy1(joy1), .joy2(joy2), .user_mode(user_mode),
        .p1_en(p1_en), .p2_en(p2_en), .osd_combo(osd_combo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0=PROBE 1=MD 2=NONE. Detect pins are seen two
    // edges late (pipeline preloaded with "low" after reset); a mode latches
    // on the edge after a low run of DET delayed samples has been observed.
    int          m_mode;
    bit          md_low_pipe[$];
    bit          d15_low_pipe[$];
    int          m_mdrun, m_d15run, m_comborun;
    logic [15:0] m_j1, m_j2;
    bit          m_p1, m_p2, m_osd;
    bit          model_valid = 0;

    task automatic model_step();
        logic [15:0] s1, s2;
        int          nmode;
        bit          lo;
        if (!reset_n) begin
            m_mode = 0;
            md_low_pipe = '{1'b1, 1'b1};
            d15_low_pipe = '{1'b1, 1'b1};
            m_mdrun = 0; m_d15run = 0; m_comborun = 0;
            m_j1 = '0; m_j2 = '0; m_p1 = 0; m_p2 = 0; m_osd = 0;
            model_valid = 1;
            return;
        end
        if (!model_valid) return;
        s1 = (m_mode == 1) ? md_joy1 : (m_mode == 0) ? db15_joy1 : 16'h0;
        s2 = (m_mode == 1) ? md_joy2 : (m_mode == 0) ? db15_joy2 : 16'h0;
        nmode = m_mode;
        if (m_mode == 0) begin
            if (m_mdrun >= DET) nmode = 1;
            else if (m_d15run >= DET) nmode = 2;
        end
        lo = md_low_pipe.pop_front();
        md_low_pipe.push_back(!md_detect);
        m_mdrun = lo ? ((m_mdrun >= DET) ? DET : m_mdrun + 1) : 0;
        lo = d15_low_pipe.pop_front();
        d15_low_pipe.push_back(!(&db15_pins));
        m_d15run = lo ? ((m_d15run >= DET) ? DET : m_d15run + 1) : 0;
        // combo: edges in a row on which the shown joy1 had both bits
        if (m_j1[10] && m_j1[6]) m_comborun = (m_comborun > COMBO) ? COMBO + 1 : m_comborun + 1;
        else m_comborun = 0;
        m_osd = (m_comborun >= COMBO + 1);
        m_j1 = (m_p1 || m_p2) ? s1 : 16'h0;
        m_j2 = (m_p1 || m_p2) ? s2 : 16'h0;
        if (s1[2]) m_p1 = 1;
        if (s2[2] && !s1[2]) m_p2 = 1;
        m_mode = nmode;
    endtask

    // Compare process: update the model on each edge, check just after it.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            if (model_valid) begin
                chk("m_joy1", joy1, m_j1);
                chk("m_joy2", joy2, m_j2);
                chk("m_user_mode", 16'(user_mode), (m_mode == 1) ? 16'h2 : 16'h1);
                chk("m_p1_en", 16'(p1_en), 16'(m_p1));
                chk("m_p2_en", 16'(p2_en), 16'(m_p2));
                chk("m_osd_combo", 16'(osd_combo), 16'(m_osd));
            end
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        wait_neg(1);
        reset_n = 1'b1;
    endtask

    int found;

    initial begin
        reset_n = 1'b0; md_detect = 1'b1; db15_pins = 3'b111;
        md_joy1 = '0; md_joy2 = '0; db15_joy1 = '0; db15_joy2 = '0;
        wait_neg(3);
        // reset values
        chk("rst_joy1", joy1, 16'h0);
        chk("rst_joy2", joy2, 16'h0);
        chk("rst_user_mode", 16'(user_mode), 16'h1);
        chk("rst_enables", 16'({p1_en, p2_en, osd_combo}), 16'h0);
        reset_n = 1'b1;
        wait_neg(1000);
        chk("idle_probe_mode", 16'(user_mode), 16'h1);

        // glitch of DET-1 cycles must not latch MD
        md_joy1 = 16'h0004; md_joy2 = 16'h0004;
        md_detect = 1'b0;
        wait_neg(DET - 1);
        md_detect = 1'b1;
        wait_neg(5);
        chk("glitch_no_md", 16'(user_mode), 16'h1);
        md_detect = 1'b0;
        found = 0;
        for (int k = 1; k <= 30; k++) begin
            wait_neg(1);
            if (found == 0 && user_mode == 2'b10) found = k;
        end
        chk("md_latency", 16'(found), 16'(2 + DET + 1));
        md_detect = 1'b1;
        wait_neg(20);
        chk("md_persist", 16'(user_mode), 16'h2);
        chk("md_p1_en", 16'(p1_en), 16'h1);
        chk("md_p2_dup_suppressed", 16'(p2_en), 16'h0);
        chk("md_joy1_out", joy1, 16'h0004);

        // DB15 missing -> NONE, outputs stay quiet
        md_joy1 = '0; md_joy2 = '0;
        do_reset();
        db15_pins = 3'b110;
        wait_neg(25);
        db15_joy1 = 16'hFFFF; db15_joy2 = 16'hFFFF;
        wait_neg(5);
        chk("none_joy1", joy1, 16'h0);
        chk("none_joy2", joy2, 16'h0);
        chk("none_p1_en", 16'(p1_en), 16'h0);
        db15_pins = 3'b111;
        do_reset();
        wait_neg(3);
        chk("probe_after_reset_p1", 16'(p1_en), 16'h1);
        chk("probe_after_reset_joy1", joy1, 16'hFFFF);

        // player enables
        db15_joy1 = '0; db15_joy2 = '0;
        do_reset();
        db15_joy1 = 16'h0004; db15_joy2 = 16'h0004;
        wait_neg(1);
        chk("first_p1_en", 16'(p1_en), 16'h1);
        chk("first_p2_en", 16'(p2_en), 16'h0);
        db15_joy1 = 16'h0000; db15_joy2 = 16'h0005;
        wait_neg(1);
        chk("p2_en_set", 16'(p2_en), 16'h1);
        wait_neg(1);
        chk("joy2_val", joy2, 16'h0005);

        // OSD combo timing relative to joy1 output
        db15_joy1 = 16'h0440;
        wait_neg(1);
        chk("combo_joy1", joy1, 16'h0440);
        wait_neg(4);
        chk("combo_not_yet", 16'(osd_combo), 16'h0);
        wait_neg(1);
        chk("combo_rise", 16'(osd_combo), 16'h1);
        wait_neg(5);
        db15_joy1 = 16'h0400;
        wait_neg(1);
        chk("combo_joy1_drop", joy1, 16'h0400);
        chk("combo_still_high", 16'(osd_combo), 16'h1);
        wait_neg(1);
        chk("combo_fall", 16'(osd_combo), 16'h0);

        // simultaneous detection: MD wins
        db15_joy1 = '0; db15_joy2 = '0;
        do_reset();
        md_detect = 1'b0; db15_pins = 3'b000;
        wait_neg(25);
        chk("md_priority", 16'(user_mode), 16'h2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
